// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcode constants and FSM state type shared by alu_seq and alu_seq_core.
package alu_seq_pkg;

  localparam logic [2:0] OP_STP  = 3'b000;
  localparam logic [2:0] OP_SHF  = 3'b001;
  localparam logic [2:0] OP_BNEG = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_ADDI = 3'b101;
  localparam logic [2:0] OP_ST   = 3'b110;
  localparam logic [2:0] OP_LD   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10,
    ST_HALT  = 2'b11
  } state_t;

endpackage

// File: rtl/alu_seq_core.sv
// alu_seq_core: combinational single-cycle result/flag datapath, including a
// barrel shifter and the decoded shift amount/direction used by the serial path.
module alu_seq_core
  import alu_seq_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             neg,
  output logic [SHW:0]     shamt,
  output logic             shr
);

  logic [WIDTH:0]   sum_s;
  logic [SHW:0]     s_field_s;
  logic [WIDTH-1:0] shifted_s;

  // Decode the signed shift field into direction and magnitude (1..WIDTH for right shifts).
  always_comb begin
    sum_s     = {1'b0, a} + {1'b0, b};
    s_field_s = b[SHW:0];
    shr       = s_field_s[SHW];
    if (shr) begin
      shamt     = (~s_field_s) + {{SHW{1'b0}}, 1'b1};
      shifted_s = a >> shamt;
    end else begin
      shamt     = s_field_s;
      shifted_s = a << shamt;
    end
  end

  // Select the operation result; carry is only meaningful for the adders.
  always_comb begin
    result = {WIDTH{1'b0}};
    carry  = 1'b0;
    case (op)
      OP_LD, OP_ST:    result = b;
      OP_ADD, OP_ADDI: begin
        result = sum_s[WIDTH-1:0];
        carry  = sum_s[WIDTH];
      end
      OP_NOR:          result = ~(a | b);
      OP_BNEG:         result = {{(WIDTH-1){1'b0}}, ~a[WIDTH-1]};
      OP_SHF:          result = shifted_s;
      OP_STP:          result = {WIDTH{1'b0}};
      default:         result = {WIDTH{1'b0}};
    endcase
  end

  // Zero and sign flags follow the selected result.
  always_comb begin
    zero = (result == {WIDTH{1'b0}});
    neg  = result[WIDTH-1];
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked sequential ALU with a serial (one bit per cycle) shifter.
// Define ALU_SEQ_BARREL_EN to replace the serial shift with a single-cycle barrel shift.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             carry,
  output logic             neg,
  output logic             halted
);

`ifdef ALU_SEQ_BARREL_EN
  localparam logic BARREL_EN = 1'b1;
`else
  localparam logic BARREL_EN = 1'b0;
`endif

  state_t           state_r, state_nxt_s;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] out_r;
  logic             zero_r, carry_r, neg_r;
  logic [SHW:0]     cnt_r;
  logic             shr_r;

  logic [WIDTH-1:0] core_result_s;
  logic             core_zero_s, core_carry_s, core_neg_s;
  logic [SHW:0]     core_shamt_s;
  logic             core_shr_s;
  logic             accept_s, start_shift_s, last_step_s;
  logic [WIDTH-1:0] step_s;

  alu_seq_core #(.WIDTH(WIDTH)) u_core (
    .op     (op),
    .a      (input_a),
    .b      (input_b),
    .result (core_result_s),
    .zero   (core_zero_s),
    .carry  (core_carry_s),
    .neg    (core_neg_s),
    .shamt  (core_shamt_s),
    .shr    (core_shr_s)
  );

  // Handshake decode and the one-bit step of the serial shifter.
  always_comb begin
    accept_s      = (state_r == ST_IDLE) && in_valid;
    start_shift_s = accept_s && (op == OP_SHF) && (core_shamt_s != {(SHW+1){1'b0}}) && !BARREL_EN;
    last_step_s   = (cnt_r == {{SHW{1'b0}}, 1'b1});
    if (shr_r) begin
      step_s = {1'b0, out_r[WIDTH-1:1]};
    end else begin
      step_s = {out_r[WIDTH-2:0], 1'b0};
    end
  end

  // FSM state register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; HALT only leaves through reset.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_shift_s) begin
          state_nxt_s = ST_SHIFT;
        end else if (accept_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (last_step_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (out_ready && (op_r == OP_STP)) begin
          state_nxt_s = ST_HALT;
        end else if (out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      ST_HALT: state_nxt_s = ST_HALT;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Result/flag registers: load on acceptance, step during SHIFT, hold otherwise.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      op_r    <= OP_STP;
      out_r   <= {WIDTH{1'b0}};
      zero_r  <= 1'b1;
      carry_r <= 1'b0;
      neg_r   <= 1'b0;
      cnt_r   <= {(SHW+1){1'b0}};
      shr_r   <= 1'b0;
    end else if (start_shift_s) begin
      op_r    <= op;
      out_r   <= input_a;
      zero_r  <= (input_a == {WIDTH{1'b0}});
      carry_r <= 1'b0;
      neg_r   <= input_a[WIDTH-1];
      cnt_r   <= core_shamt_s;
      shr_r   <= core_shr_s;
    end else if (accept_s) begin
      op_r    <= op;
      out_r   <= core_result_s;
      zero_r  <= core_zero_s;
      carry_r <= core_carry_s;
      neg_r   <= core_neg_s;
    end else if (state_r == ST_SHIFT) begin
      out_r   <= step_s;
      zero_r  <= (step_s == {WIDTH{1'b0}});
      carry_r <= 1'b0;
      neg_r   <= step_s[WIDTH-1];
      cnt_r   <= cnt_r - {{SHW{1'b0}}, 1'b1};
    end else begin
      out_r   <= out_r;
    end
  end

  // Outputs are driven straight from registers or decoded from the state register.
  always_comb begin
    in_ready  = (state_r == ST_IDLE);
    out_valid = (state_r == ST_DONE);
    halted    = (state_r == ST_HALT);
    out       = out_r;
    zero      = zero_r;
    carry     = carry_r;
    neg       = neg_r;
  end

endmodule
